// File: rtl/piradip_sample_capture_pkg.sv
// piradip_sample_capture_pkg
// Shared types for the AXI-stream sample capture engine.
//   cap_mode_t  : capture mode as written by the CSR block (2-bit encoding)
//   cap_state_t : capture engine FSM states
//   is_capturing: true for the states in which the stream is accepted
package piradip_sample_capture_pkg;

  typedef enum logic [1:0] {
    OFF        = 2'd0,
    CONTINUOUS = 2'd1,
    ONE_SHOT   = 2'd2,
    TRIGGERED  = 2'd3
  } cap_mode_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    ARMED = 3'd2,
    POST  = 3'd3,
    DONE  = 3'd4
  } cap_state_t;

  // The stream is accepted in every state that is still filling the ring.
  function automatic logic is_capturing(input cap_state_t s);
    return (s == RUN) || (s == ARMED) || (s == POST);
  endfunction

endpackage

// File: rtl/piradip_ring_addr_gen.sv
// piradip_ring_addr_gen
// Ring address counter for the sample RAM.
//   aclk, aresetn : clock, async active-low reset (addr returns to 0)
//   load          : reload addr with load_addr (wins over advance)
//   load_addr     : reload value
//   advance       : step to the next ring address
//   ring_start    : first ring address
//   ring_end      : last ring address (inclusive)
//   addr          : current ring address
//   wrap          : combinational pulse, this advance returns to ring_start
module piradip_ring_addr_gen #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic                  advance,
  input  logic [ADDR_WIDTH-1:0] ring_start,
  input  logic [ADDR_WIDTH-1:0] ring_end,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  wrap
);

  logic [ADDR_WIDTH-1:0] addr_q;

  // Equality-only compare: with ring_end below ring_start the counter runs
  // through the top of memory and rolls over naturally before reaching the end.
  assign wrap = advance && !load && (addr_q == ring_end);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      addr_q <= '0;
    end else if (load) begin
      addr_q <= load_addr;
    end else if (advance) begin
      addr_q <= (addr_q == ring_end) ? ring_start : addr_q + 1'b1;
    end
  end

  assign addr = addr_q;

endmodule

// File: rtl/piradip_axis_sample_capture.sv
// piradip_axis_sample_capture
// Multi-channel AXI-stream sample capture engine writing one beat per RAM word.
//   aclk, aresetn        : clock, async active-low reset
//   s_tdata/tvalid/tready: sample stream, lane k = s_tdata[k*SAMPLE_WIDTH +: SAMPLE_WIDTH]
//   trigger              : level input, rising edge is the trigger event
//   cfg_*                : configuration, latched on the cfg_update pulse
//   mem_we/be/addr/wdata : zero-latency write port of the sample RAM
//   sts_active           : engine is accepting beats
//   sts_wrapped          : ring wrapped since the last cfg_update
//   sts_trig_addr        : RAM address of the trigger beat
//   sts_done             : one-cycle pulse on completion
module piradip_axis_sample_capture
  import piradip_sample_capture_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 16,
  parameter int NUM_CHANNELS = 4,
  parameter int ADDR_WIDTH   = 12
) (
  input  logic                                 aclk,
  input  logic                                 aresetn,
  input  logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] s_tdata,
  input  logic                                 s_tvalid,
  output logic                                 s_tready,
  input  logic                                 trigger,
  input  logic                                 cfg_update,
  input  logic [1:0]                           cfg_mode,
  input  logic [ADDR_WIDTH-1:0]                cfg_start_offset,
  input  logic [ADDR_WIDTH-1:0]                cfg_end_offset,
  input  logic [ADDR_WIDTH-1:0]                cfg_post_count,
  input  logic [NUM_CHANNELS-1:0]              cfg_chan_mask,
  output logic                                 mem_we,
  output logic [NUM_CHANNELS-1:0]              mem_be,
  output logic [ADDR_WIDTH-1:0]                mem_addr,
  output logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] mem_wdata,
  output logic                                 sts_active,
  output logic                                 sts_wrapped,
  output logic [ADDR_WIDTH-1:0]                sts_trig_addr,
  output logic                                 sts_done
);

  cap_state_t state, state_next;

  cap_mode_t               mode_q;
  logic [ADDR_WIDTH-1:0]   start_q;
  logic [ADDR_WIDTH-1:0]   end_q;
  logic [ADDR_WIDTH-1:0]   post_q;
  logic [NUM_CHANNELS-1:0] mask_q;
  logic [ADDR_WIDTH-1:0]   cnt_q;
  logic [ADDR_WIDTH-1:0]   trig_addr_q;
  logic                    trigger_q;
  logic                    wrapped_q;
  logic                    done_q;

  logic                    beat;
  logic                    trig_rise;
  logic [ADDR_WIDTH-1:0]   addr;
  logic                    wrap;

  assign s_tready  = is_capturing(state);
  assign beat      = s_tvalid && s_tready;
  assign trig_rise = trigger && !trigger_q;

  piradip_ring_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_gen (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .load       (cfg_update),
    .load_addr  (cfg_start_offset),
    .advance    (beat),
    .ring_start (start_q),
    .ring_end   (end_q),
    .addr       (addr),
    .wrap       (wrap)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // cfg_update restarts from any state, so it is decoded ahead of the state case.
  always_comb begin
    state_next = state;
    if (cfg_update) begin
      case (cfg_mode)
        CONTINUOUS, ONE_SHOT: state_next = RUN;
        TRIGGERED:            state_next = ARMED;
        default:              state_next = IDLE;
      endcase
    end else begin
      case (state)
        RUN: begin
          if ((mode_q == ONE_SHOT) && beat && (addr == end_q)) begin
            state_next = DONE;
          end
        end
        ARMED: begin
          if (trig_rise) begin
            state_next = (post_q == '0) ? DONE : POST;
          end
        end
        POST: begin
          if (beat && (cnt_q == ADDR_WIDTH'(1))) begin
            state_next = DONE;
          end
        end
        default: state_next = state;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      mode_q  <= OFF;
      start_q <= '0;
      end_q   <= '0;
      post_q  <= '0;
      mask_q  <= '0;
    end else if (cfg_update) begin
      mode_q  <= cap_mode_t'(cfg_mode);
      start_q <= cfg_start_offset;
      end_q   <= cfg_end_offset;
      post_q  <= cfg_post_count;
      mask_q  <= cfg_chan_mask;
    end
  end

  // Sampled unconditionally so a trigger already high when arming is not an edge.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      trigger_q <= 1'b0;
    end else begin
      trigger_q <= trigger;
    end
  end

  // The trigger beat itself is not counted; cnt holds the beats still to write.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt_q       <= '0;
      trig_addr_q <= '0;
    end else if (!cfg_update) begin
      if ((state == ARMED) && trig_rise) begin
        cnt_q       <= post_q;
        trig_addr_q <= addr;
      end else if ((state == POST) && beat) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wrapped_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      if (cfg_update) begin
        wrapped_q <= 1'b0;
      end else if (wrap) begin
        wrapped_q <= 1'b1;
      end
      done_q <= (state_next == DONE) && (state != DONE);
    end
  end

  assign mem_we        = beat;
  assign mem_be        = mask_q;
  assign mem_addr      = addr;
  assign mem_wdata     = s_tdata;
  assign sts_active    = is_capturing(state);
  assign sts_wrapped   = wrapped_q;
  assign sts_trig_addr = trig_addr_q;
  assign sts_done      = done_q;

endmodule

// File: tb/tb_piradip_axis_sample_capture.sv
// tb_piradip_axis_sample_capture
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized phase, all outputs compared every cycle against a behavioural model.
module tb_piradip_axis_sample_capture;

  localparam int SW = 16;
  localparam int NC = 4;
  localparam int AW = 12;
  localparam int RING = 4096;

  logic            aclk;
  logic            aresetn;
  logic [NC*SW-1:0] s_tdata;
  logic            s_tvalid;
  logic            s_tready;
  logic            trigger;
  logic            cfg_update;
  logic [1:0]      cfg_mode;
  logic [AW-1:0]   cfg_start_offset;
  logic [AW-1:0]   cfg_end_offset;
  logic [AW-1:0]   cfg_post_count;
  logic [NC-1:0]   cfg_chan_mask;
  logic            mem_we;
  logic [NC-1:0]   mem_be;
  logic [AW-1:0]   mem_addr;
  logic [NC*SW-1:0] mem_wdata;
  logic            sts_active;
  logic            sts_wrapped;
  logic [AW-1:0]   sts_trig_addr;
  logic            sts_done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [AW-1:0] wr_addr_log[$];
  logic [NC-1:0] wr_be_log[$];
  int            done_count;

  // Behavioural model: capture described as "accepting / waiting for trigger /
  // beats left after trigger", with plain integer ring arithmetic.
  int       m_addr, m_start, m_end, m_post, m_mode, m_trig, m_post_left;
  bit [3:0] m_mask;
  bit       m_accepting, m_waiting, m_wrapped, m_trigq, m_done_pulse;

  piradip_axis_sample_capture #(
    .SAMPLE_WIDTH (SW),
    .NUM_CHANNELS (NC),
    .ADDR_WIDTH   (AW)
  ) dut (
    .aclk             (aclk),
    .aresetn          (aresetn),
    .s_tdata          (s_tdata),
    .s_tvalid         (s_tvalid),
    .s_tready         (s_tready),
    .trigger          (trigger),
    .cfg_update       (cfg_update),
    .cfg_mode         (cfg_mode),
    .cfg_start_offset (cfg_start_offset),
    .cfg_end_offset   (cfg_end_offset),
    .cfg_post_count   (cfg_post_count),
    .cfg_chan_mask    (cfg_chan_mask),
    .mem_we           (mem_we),
    .mem_be           (mem_be),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .sts_active       (sts_active),
    .sts_wrapped      (sts_wrapped),
    .sts_trig_addr    (sts_trig_addr),
    .sts_done         (sts_done)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_addr = 0; m_start = 0; m_end = 0; m_post = 0; m_mode = 0;
    m_trig = 0; m_post_left = 0; m_mask = '0;
    m_accepting = 0; m_waiting = 0; m_wrapped = 0; m_trigq = 0; m_done_pulse = 0;
  endtask

  // Compare on the falling edge (inputs are stable), then advance the model
  // to what the next rising edge must produce.
  always @(negedge aclk) begin
    bit beat, rise, fin;
    int old;
    if (!aresetn) modelReset();
    beat = s_tvalid && m_accepting;
    checkOutput("s_tready",      64'(s_tready),      64'(m_accepting));
    checkOutput("mem_we",        64'(mem_we),        64'(beat));
    checkOutput("mem_addr",      64'(mem_addr),      64'(m_addr));
    checkOutput("mem_wdata",     64'(mem_wdata),     64'(s_tdata));
    checkOutput("mem_be",        64'(mem_be),        64'(m_mask));
    checkOutput("sts_active",    64'(sts_active),    64'(m_accepting));
    checkOutput("sts_wrapped",   64'(sts_wrapped),   64'(m_wrapped));
    checkOutput("sts_trig_addr", 64'(sts_trig_addr), 64'(m_trig));
    checkOutput("sts_done",      64'(sts_done),      64'(m_done_pulse));
    if (mem_we) begin
      wr_addr_log.push_back(mem_addr);
      wr_be_log.push_back(mem_be);
    end
    if (sts_done) done_count++;
    if (aresetn) begin
      rise = trigger && !m_trigq;
      m_trigq = trigger;
      m_done_pulse = 0;
      if (cfg_update) begin
        m_mode = int'(cfg_mode);
        m_start = int'(cfg_start_offset);
        m_end = int'(cfg_end_offset);
        m_post = int'(cfg_post_count);
        m_mask = cfg_chan_mask;
        m_addr = m_start;
        m_wrapped = 0;
        m_accepting = (m_mode != 0);
        m_waiting = (m_mode == 3);
        m_post_left = 0;
      end else begin
        old = m_addr;
        fin = 0;
        if (beat) begin
          if (old == m_end) begin
            m_addr = m_start;
            m_wrapped = 1;
          end else begin
            m_addr = (old + 1) % RING;
          end
        end
        if (m_mode == 2 && m_accepting && beat && old == m_end) fin = 1;
        if (m_mode == 3 && m_accepting && m_waiting) begin
          if (rise) begin
            m_trig = old;
            m_waiting = 0;
            if (m_post == 0) fin = 1;
            else m_post_left = m_post;
          end
        end else if (m_mode == 3 && m_accepting && beat && m_post_left > 0) begin
          m_post_left--;
          if (m_post_left == 0) fin = 1;
        end
        if (fin) begin
          m_accepting = 0;
          m_done_pulse = 1;
        end
      end
    end
  end

  // Drive one cycle of stream/trigger inputs; returns just after the rising edge.
  task automatic applyStimulus(input bit valid, input bit trig);
    s_tvalid = valid;
    s_tdata  = {$urandom, $urandom};
    trigger  = trig;
    @(posedge aclk);
    #1;
  endtask

  task automatic doCfg(input logic [1:0] mode, input logic [AW-1:0] start,
                       input logic [AW-1:0] stop, input logic [AW-1:0] post,
                       input logic [NC-1:0] mask);
    cfg_mode = mode;
    cfg_start_offset = start;
    cfg_end_offset = stop;
    cfg_post_count = post;
    cfg_chan_mask = mask;
    cfg_update = 1'b1;
    applyStimulus(1'b0, trigger);
    cfg_update = 1'b0;
  endtask

  task automatic clearLog();
    wr_addr_log.delete();
    wr_be_log.delete();
    done_count = 0;
  endtask

  initial begin
    int exp1[10] = '{4, 5, 6, 7, 4, 5, 6, 7, 4, 5};
    int exp6[10] = '{4090, 4091, 4092, 4093, 4094, 4095, 0, 1, 2, 4090};
    logic [AW-1:0] trig_before;

    aresetn = 1'b0;
    s_tdata = '0; s_tvalid = 1'b0; trigger = 1'b0; cfg_update = 1'b0;
    cfg_mode = '0; cfg_start_offset = '0; cfg_end_offset = '0;
    cfg_post_count = '0; cfg_chan_mask = '0;
    done_count = 0;
    repeat (3) @(posedge aclk);
    #1;
    checkOutput("reset_tready", 64'(s_tready), 64'd0);
    checkOutput("reset_active", 64'(sts_active), 64'd0);
    checkOutput("reset_addr",   64'(mem_addr), 64'd0);
    checkOutput("reset_trig",   64'(sts_trig_addr), 64'd0);
    aresetn = 1'b1;
    applyStimulus(1'b1, 1'b0);
    checkOutput("idle_no_write", 64'(wr_addr_log.size()), 64'd0);

    $display("[TB] continuous ring 4..7");
    doCfg(2'd1, 12'd4, 12'd7, 12'd0, 4'hF);
    clearLog();
    repeat (3) applyStimulus(1'b1, 1'b0);
    checkOutput("s1_not_wrapped", 64'(sts_wrapped), 64'd0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("s1_wrapped_at_beat5", 64'(sts_wrapped), 64'd1);
    repeat (6) applyStimulus(1'b1, 1'b0);
    checkOutput("s1_write_count", 64'(wr_addr_log.size()), 64'd10);
    for (int i = 0; i < 10 && i < wr_addr_log.size(); i++)
      checkOutput("s1_addr_seq", 64'(wr_addr_log[i]), 64'(exp1[i]));

    $display("[TB] one-shot 0..3");
    doCfg(2'd2, 12'd0, 12'd3, 12'd0, 4'hF);
    clearLog();
    repeat (4) applyStimulus(1'b1, 1'b0);
    checkOutput("s2_tready_low", 64'(s_tready), 64'd0);
    checkOutput("s2_done_pulse", 64'(sts_done), 64'd1);
    repeat (4) applyStimulus(1'b1, 1'b0);
    checkOutput("s2_write_count", 64'(wr_addr_log.size()), 64'd4);
    checkOutput("s2_done_count", 64'(done_count), 64'd1);
    checkOutput("s2_last_addr", 64'(wr_addr_log[wr_addr_log.size()-1]), 64'd3);

    $display("[TB] triggered post 5");
    doCfg(2'd3, 12'd0, 12'd15, 12'd5, 4'hF);
    clearLog();
    repeat (19) applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1);
    repeat (10) applyStimulus(1'b1, 1'b0);
    checkOutput("s3_trig_addr", 64'(sts_trig_addr), 64'd3);
    checkOutput("s3_write_count", 64'(wr_addr_log.size()), 64'd25);
    for (int i = 0; i < 6 && wr_addr_log.size() == 25; i++)
      checkOutput("s3_post_addr", 64'(wr_addr_log[19+i]), 64'(3+i));
    checkOutput("s3_done_count", 64'(done_count), 64'd1);
    checkOutput("s3_tready_low", 64'(s_tready), 64'd0);

    $display("[TB] triggered post 0 with idle stream");
    doCfg(2'd3, 12'd0, 12'd15, 12'd0, 4'hF);
    clearLog();
    repeat (9) applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("s4_trig_addr", 64'(sts_trig_addr), 64'd9);
    checkOutput("s4_done_pulse", 64'(sts_done), 64'd1);
    checkOutput("s4_tready_low", 64'(s_tready), 64'd0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("s4_write_count", 64'(wr_addr_log.size()), 64'd9);

    $display("[TB] lane mask and re-arm during post");
    doCfg(2'd3, 12'd10, 12'd20, 12'd10, 4'b0101);
    clearLog();
    repeat (3) applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1);
    repeat (3) applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < wr_be_log.size(); i++)
      checkOutput("s5_mem_be", 64'(wr_be_log[i]), 64'h5);
    doCfg(2'd3, 12'd10, 12'd20, 12'd10, 4'b0101);
    checkOutput("s5_addr_reload", 64'(mem_addr), 64'd10);
    checkOutput("s5_active", 64'(sts_active), 64'd1);
    repeat (8) applyStimulus(1'b1, 1'b0);
    checkOutput("s5_still_armed", 64'(sts_active), 64'd1);
    checkOutput("s5_no_done", 64'(done_count), 64'd0);

    $display("[TB] ring through top of memory, trigger high at arm");
    applyStimulus(1'b0, 1'b1);
    trig_before = sts_trig_addr;
    doCfg(2'd3, 12'd4090, 12'd2, 12'd1, 4'hF);
    clearLog();
    repeat (10) applyStimulus(1'b1, 1'b1);
    checkOutput("s6_write_count", 64'(wr_addr_log.size()), 64'd10);
    for (int i = 0; i < 10 && i < wr_addr_log.size(); i++)
      checkOutput("s6_addr_seq", 64'(wr_addr_log[i]), 64'(exp6[i]));
    checkOutput("s6_no_capture", 64'(sts_trig_addr), 64'(trig_before));
    checkOutput("s6_active", 64'(sts_active), 64'd1);
    checkOutput("s6_wrapped", 64'(sts_wrapped), 64'd1);

    $display("[TB] randomized phase");
    for (int ep = 0; ep < 60; ep++) begin
      logic [AW-1:0] st;
      st = AW'($urandom_range(0, RING-1));
      doCfg(2'($urandom_range(0, 3)), st,
            ($urandom_range(0, 5) == 0) ? AW'($urandom) : AW'(st + AW'($urandom_range(0, 20))),
            AW'($urandom_range(0, 8)), NC'($urandom));
      for (int c = 0; c < 60; c++) begin
        if ($urandom_range(0, 40) == 0) begin
          cfg_mode = 2'($urandom_range(0, 3));
          cfg_post_count = AW'($urandom_range(0, 6));
          cfg_chan_mask = NC'($urandom);
          cfg_update = 1'b1;
        end
        applyStimulus($urandom_range(0, 9) < 7,
                      ($urandom_range(0, 4) == 0) ? ~trigger : trigger);
        cfg_update = 1'b0;
        if (c == 30 && (ep % 10) == 7) begin
          #2 aresetn = 1'b0;
          @(posedge aclk);
          #1 aresetn = 1'b1;
        end
      end
    end

    applyStimulus(1'b0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
